sprite_draw_engine: RTL and testbench
=====================================

# sprite_draw_engine

Responder side of the view FSM's draw handshake: accepts a held `enable_draw` request, rasterises one rectangular sprite from a colour ROM into the VGA adapter's pixel-write port, then answers with a one-cycle `draw_done`. One instance serves each drawable object class (background, gold, stone, diamond, hook, number, banners); the view FSM selects the instance by its enable line.

## Interface
- `X_W`, 8, VGA x coordinate width (160-wide screen)
- `Y_W`, 7, VGA y coordinate width (120-high screen)
- `DIM_W`, 6, sprite width/height field width
- `COLOUR_W`, 3, pixel colour width
- `ADDR_W`, 12, colour ROM address width
- `SCREEN_W`, 160, pixels with x ≥ this are clipped
- `SCREEN_H`, 120, pixels with y ≥ this are clipped
- `TRANSPARENT_COLOUR`, 3'b000, key colour (used only with `SPRITE_TRANSPARENT_EN`)
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high; returns block to IDLE
- `enable_draw`  in  1  request, held high by the view FSM until `draw_done` is seen
- `obj_x`  in  X_W  sprite top-left x; sampled in LOAD
- `obj_y`  in  Y_W  sprite top-left y; sampled in LOAD
- `obj_w`  in  DIM_W  sprite width in pixels; sampled in LOAD
- `obj_h`  in  DIM_W  sprite height in pixels; sampled in LOAD
- `rom_base`  in  ADDR_W  ROM address of the sprite's first pixel; sampled in LOAD
- `rom_addr`  out  ADDR_W  colour ROM read address
- `rom_q`  in  COLOUR_W  ROM data, valid one cycle after `rom_addr`
- `vga_x`  out  X_W  pixel x
- `vga_y`  out  Y_W  pixel y
- `vga_colour`  out  COLOUR_W  pixel colour
- `vga_plot`  out  1  pixel write strobe
- `draw_done`  out  1  one-cycle completion pulse
- `busy`  out  1  high in LOAD, RUN, FLUSH

## Operation
- States: IDLE, LOAD, RUN, FLUSH, DONE, RELEASE.
- IDLE: when `enable_draw`=1, go to LOAD.
- LOAD: latch the obj_* and `rom_base` inputs; clear col/row counters; load address register with `rom_base`. If w=0 or h=0, go to DONE; otherwise go to RUN.
- RUN: issue one `rom_addr` per cycle, raster order (col fastest). The address register increments by 1 per pixel; no multiplier. After the pixel at col=w-1, row=h-1 is issued, go to FLUSH.
- Pixel stage: a one-stage pipeline carries x = obj_x+col and y = obj_y+row alongside the ROM read. `vga_plot` is asserted the cycle `rom_q` is valid. `vga_plot` is suppressed when x ≥ SCREEN_W or y ≥ SCREEN_H; the coordinate sums use X_W+1 / Y_W+1 bits so they never wrap.
- FLUSH: the last pixel is emitted; go to DONE.
- DONE: `draw_done`=1 for exactly one cycle; go to RELEASE.
- RELEASE: wait for `enable_draw`=0, then go to IDLE. A request still held after done never triggers a redraw.
- `enable_draw` dropping in LOAD or RUN aborts the draw: pipeline `vga_plot` is forced 0, no `draw_done` is issued, and the block goes to IDLE.
- Input changes after LOAD have no effect on the sprite being drawn.

## Timing
- Reset values: all outputs 0, state IDLE. Reset mid-draw takes effect at the next edge; `vga_plot` is 0 from that cycle.
- N = IDLE cycle that sees `enable_draw`=1. LOAD is at N+1. RUN covers N+2 … N+1+W·H. Plots fall on N+3 … N+2+W·H (FLUSH is the last). `draw_done` is at N+3+W·H.
- Zero-size sprite: LOAD at N+1, `draw_done` at N+2, no plots.
- Back-to-back draws: minimum 2 idle cycles between `draw_done` and the next LOAD (RELEASE→IDLE→LOAD), which matches the FSM's DONE/WAIT re-entry.

## Configuration
- `SPRITE_TRANSPARENT_EN` defined: pixels whose `rom_q` equals TRANSPARENT_COLOUR have `vga_plot` suppressed. Timing, address sequence and `draw_done` are unchanged.
- Undefined: every in-screen pixel is plotted, including the key colour.

## Structure
- Shared package `view_pkg`: screen dimensions, coordinate/colour/dim widths, the state encoding typedef, default TRANSPARENT_COLOUR.
- One natural sub-module: `sprite_raster_counter` (col/row counters, address increment, last-pixel flag). FSM and pixel pipeline stay in the top module.

## Test plan
- 2×2 sprite at (10,20), `rom_base`=0x040, ROM returns 1,2,3,4 → plots (10,20,1),(11,20,2),(10,21,3),(11,21,4) on N+3…N+6; `draw_done` at N+7; `rom_addr` 0x040…0x043.
- w=0, h=5 → no plots, `draw_done` at N+2, `busy` high only at N+1.
- 4×1 at x=158 → only x=158,159 plotted; x=160,161 cycles have `vga_plot`=0; `draw_done` still at N+7.
- With `SPRITE_TRANSPARENT_EN`, 3×1 sprite whose ROM returns 5,0,6 → plots only the first and third pixels; the same test without the macro plots all three.
- `enable_draw` held 20 cycles past `draw_done` → exactly one draw. Drop then re-raise the request → second full draw with identical plots.
- `reset`=1 at N+4 of a 4×4 draw → `vga_plot`,`draw_done`,`busy`=0 from N+5, state IDLE. A new request then completes normally.

Source files
------------

// File: rtl/view_pkg.sv
// Shared view-side constants for the sprite draw engines: screen geometry,
// field widths, draw FSM state encoding and the on-screen test.
package view_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int DIM_W    = 6;
    localparam int COLOUR_W = 3;
    localparam int ADDR_W   = 12;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = 3'b000;

    localparam logic [X_W:0] X_LIMIT = 9'd160;
    localparam logic [Y_W:0] Y_LIMIT = 8'd120;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4,
        ST_RELEASE = 3'd5
    } draw_state_e;

    // Coordinates arrive one bit wider than the screen fields so they never wrap.
    function automatic logic in_screen(input logic [X_W:0] x, input logic [Y_W:0] y);
        return (x < X_LIMIT) && (y < Y_LIMIT);
    endfunction

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Draw handshake, colour ROM port and VGA pixel-write port of one sprite engine.
// master = view FSM / ROM / VGA side, slave = the engine.
interface sprite_draw_engine_if;
    import view_pkg::*;

    logic                enable_draw;
    logic [X_W-1:0]      obj_x;
    logic [Y_W-1:0]      obj_y;
    logic [DIM_W-1:0]    obj_w;
    logic [DIM_W-1:0]    obj_h;
    logic [ADDR_W-1:0]   rom_base;
    logic [ADDR_W-1:0]   rom_addr;
    logic [COLOUR_W-1:0] rom_q;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                draw_done;
    logic                busy;

    modport master (
        output enable_draw, obj_x, obj_y, obj_w, obj_h, rom_base, rom_q,
        input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, draw_done, busy
    );

    modport slave (
        input  enable_draw, obj_x, obj_y, obj_w, obj_h, rom_base, rom_q,
        output rom_addr, vga_x, vga_y, vga_colour, vga_plot, draw_done, busy
    );

endinterface

// File: rtl/sprite_raster_counter.sv
// Raster walker for one sprite: column/row counters, linear ROM address and
// a flag marking the final pixel of the rectangle.
module sprite_raster_counter
    import view_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [DIM_W-1:0]  w,
    input  logic [DIM_W-1:0]  h,
    input  logic [ADDR_W-1:0] base,
    output logic [DIM_W-1:0]  col,
    output logic [DIM_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [DIM_W-1:0]  w_r;
    logic [DIM_W-1:0]  h_r;
    logic [DIM_W-1:0]  col_r;
    logic [DIM_W-1:0]  row_r;
    logic [ADDR_W-1:0] addr_r;

    // Counter and address registers; the address simply follows raster order.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_r    <= {DIM_W{1'b0}};
            h_r    <= {DIM_W{1'b0}};
            col_r  <= {DIM_W{1'b0}};
            row_r  <= {DIM_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else if (load) begin
            w_r    <= w;
            h_r    <= h;
            col_r  <= {DIM_W{1'b0}};
            row_r  <= {DIM_W{1'b0}};
            addr_r <= base;
        end else if (step) begin
            addr_r <= addr_r + 12'd1;
            if (col_r == w_r - 6'd1) begin
                col_r <= {DIM_W{1'b0}};
                row_r <= row_r + 6'd1;
            end else begin
                col_r <= col_r + 6'd1;
            end
        end else begin
            addr_r <= addr_r;
        end
    end

    assign col  = col_r;
    assign row  = row_r;
    assign addr = addr_r;
    assign last = (col_r == w_r - 6'd1) && (row_r == h_r - 6'd1);

endmodule

// File: rtl/sprite_draw_engine.sv
// Draw-handshake responder: rasterises one sprite from a colour ROM into the
// VGA pixel port. Optional colour keying is enabled by SPRITE_TRANSPARENT_EN.
module sprite_draw_engine
    import view_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    sprite_draw_engine_if.slave bus
);

    draw_state_e         state_r;
    draw_state_e         state_s;
    logic                load_s;
    logic                step_s;
    logic                busy_s;
    logic                done_s;
    logic                zero_size_s;
    logic [X_W-1:0]      x_r;
    logic [Y_W-1:0]      y_r;
    logic [DIM_W-1:0]    col_s;
    logic [DIM_W-1:0]    row_s;
    logic [ADDR_W-1:0]   addr_s;
    logic                last_s;
    logic [X_W:0]        sum_x_s;
    logic [Y_W:0]        sum_y_s;
    logic                pix_valid_r;
    logic                in_screen_r;
    logic [X_W-1:0]      px_r;
    logic [Y_W-1:0]      py_r;
    logic                plot_s;
    logic [COLOUR_W-1:0] colour_s;

    sprite_raster_counter u_counter (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .step  (step_s),
        .w     (bus.obj_w),
        .h     (bus.obj_h),
        .base  (bus.rom_base),
        .col   (col_s),
        .row   (row_s),
        .addr  (addr_s),
        .last  (last_s)
    );

    assign zero_size_s = (bus.obj_w == {DIM_W{1'b0}}) || (bus.obj_h == {DIM_W{1'b0}});

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; a dropped request during LOAD/RUN abandons the sprite.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.enable_draw) state_s = ST_LOAD;
                else                 state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (!bus.enable_draw) state_s = ST_IDLE;
                else if (zero_size_s) state_s = ST_DONE;
                else                  state_s = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.enable_draw) state_s = ST_IDLE;
                else if (last_s)      state_s = ST_FLUSH;
                else                  state_s = ST_RUN;
            end
            ST_FLUSH:   state_s = ST_DONE;
            ST_DONE:    state_s = ST_RELEASE;
            ST_RELEASE: begin
                if (bus.enable_draw) state_s = ST_RELEASE;
                else                 state_s = ST_IDLE;
            end
            default:    state_s = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_LOAD: begin
                load_s = 1'b1;
                busy_s = 1'b1;
            end
            ST_RUN: begin
                step_s = bus.enable_draw;
                busy_s = 1'b1;
            end
            ST_FLUSH: busy_s = 1'b1;
            ST_DONE:  done_s = 1'b1;
            default: begin
                load_s = 1'b0;
                busy_s = 1'b0;
            end
        endcase
    end

    // Sprite origin captured in LOAD so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r <= {X_W{1'b0}};
            y_r <= {Y_W{1'b0}};
        end else if (load_s) begin
            x_r <= bus.obj_x;
            y_r <= bus.obj_y;
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

    assign sum_x_s = {1'b0, x_r} + {{(X_W + 1 - DIM_W){1'b0}}, col_s};
    assign sum_y_s = {1'b0, y_r} + {{(Y_W + 1 - DIM_W){1'b0}}, row_s};

    // Pixel stage: coordinates travel alongside the one-cycle ROM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid_r <= 1'b0;
            in_screen_r <= 1'b0;
            px_r        <= {X_W{1'b0}};
            py_r        <= {Y_W{1'b0}};
        end else begin
            pix_valid_r <= step_s;
            if (step_s) begin
                px_r        <= sum_x_s[X_W-1:0];
                py_r        <= sum_y_s[Y_W-1:0];
                in_screen_r <= in_screen(sum_x_s, sum_y_s);
            end else begin
                in_screen_r <= in_screen_r;
            end
        end
    end

    // Pixel write strobe and colour, qualified in the cycle rom_q is valid.
    always_comb begin
        colour_s = {COLOUR_W{1'b0}};
        plot_s   = 1'b0;
        if (pix_valid_r) begin
            colour_s = bus.rom_q;
`ifdef SPRITE_TRANSPARENT_EN
            plot_s   = in_screen_r && (bus.rom_q != TRANSPARENT_COLOUR);
`else
            plot_s   = in_screen_r;
`endif
        end else begin
            colour_s = {COLOUR_W{1'b0}};
            plot_s   = 1'b0;
        end
    end

    assign bus.rom_addr   = addr_s;
    assign bus.vga_x      = px_r;
    assign bus.vga_y      = py_r;
    assign bus.vga_colour = colour_s;
    assign bus.vga_plot   = plot_s;
    assign bus.draw_done  = done_s;
    assign bus.busy       = busy_s;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine: a table of sprites with hand-computed
// plot/done timing, plus abort, held-request and mid-draw reset sequences.
module tb_sprite_draw_engine;
    import view_pkg::*;

    logic clk;
    logic reset;

    sprite_draw_engine_if bus_if();

    sprite_draw_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [COLOUR_W-1:0] rom_mem [0:4095];
    always @(posedge clk) bus_if.rom_q <= rom_mem[bus_if.rom_addr];

    typedef struct {
        int off;
        int x;
        int y;
        int c;
    } plot_t;

    typedef struct {
        int x, y, w, h, base;
        int c0, c1, c2, c3;
        int exp_n, exp_done, exp_busy;
        int f_off, f_x, f_y, f_c;
        int l_off, l_x, l_y, l_c;
    } vec_t;

    plot_t plots[$];
    plot_t saved[$];
    vec_t  vecs[7];
    int    addr_log[256];
    int    done_off;
    int    done_cnt;
    int    busy_cnt;
    int    total;
    int    bad;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the request, log every cycle from N+1 on, drop it hold cycles after done.
    task automatic run_draw(input int x, input int y, input int w, input int h,
                            input int base, input int hold);
        plots.delete();
        done_off = -1;
        done_cnt = 0;
        busy_cnt = 0;
        bus_if.obj_x       = 8'(x);
        bus_if.obj_y       = 7'(y);
        bus_if.obj_w       = 6'(w);
        bus_if.obj_h       = 6'(h);
        bus_if.rom_base    = 12'(base);
        bus_if.enable_draw = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            addr_log[c] = int'(bus_if.rom_addr);
            if (bus_if.vga_plot)
                plots.push_back('{c, int'(bus_if.vga_x), int'(bus_if.vga_y), int'(bus_if.vga_colour)});
            if (bus_if.busy) busy_cnt++;
            if (bus_if.draw_done) begin
                done_cnt++;
                if (done_off < 0) done_off = c;
            end
            if (c == 2) begin
                bus_if.obj_x    = 8'd99;
                bus_if.obj_y    = 7'd33;
                bus_if.obj_w    = 6'd17;
                bus_if.obj_h    = 6'd9;
                bus_if.rom_base = 12'h7C0;
            end
            if (done_off >= 0 && c == done_off + hold) bus_if.enable_draw = 1'b0;
            if (done_off >= 0 && c >= done_off + hold + 3) break;
        end
        check("done_seen", int'(done_off >= 0), 1);
        bus_if.enable_draw = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_plots;
        total = 0;
        bad   = 0;
        for (int a = 0; a < 4096; a++) rom_mem[a] = 3'd0;
`ifdef SPRITE_TRANSPARENT_EN
        n_plots = 2;
`else
        n_plots = 3;
`endif
        //           x    y   w  h  base    colours     n  done busy  first         last
        vecs[0] = '{10,  20,  2, 2, 'h040, 1, 2, 3, 4, 4,       7, 6, 3, 10, 20, 1, 6, 11, 21, 4};
        vecs[1] = '{5,   5,   0, 5, 'h100, 1, 1, 1, 1, 0,       2, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{158, 3,   4, 1, 'h200, 1, 2, 3, 4, 2,       7, 6, 3, 158, 3, 1, 4, 159, 3, 2};
        vecs[3] = '{0,   0,   3, 1, 'h300, 5, 0, 6, 0, n_plots, 6, 5, 3, 0, 0, 5, 5, 2, 0, 6};
        vecs[4] = '{50,  117, 1, 4, 'h010, 7, 6, 5, 4, 3,       7, 6, 3, 50, 117, 7, 5, 50, 119, 5};
        vecs[5] = '{159, 119, 1, 1, 'h0AA, 3, 0, 0, 0, 1,       4, 3, 3, 159, 119, 3, 3, 159, 119, 3};
        vecs[6] = '{7,   7,   3, 0, 'h120, 2, 2, 2, 2, 0,       2, 1, 0, 0, 0, 0, 0, 0, 0, 0};

        reset              = 1'b1;
        bus_if.enable_draw = 1'b0;
        bus_if.obj_x       = 8'd0;
        bus_if.obj_y       = 7'd0;
        bus_if.obj_w       = 6'd0;
        bus_if.obj_h       = 6'd0;
        bus_if.rom_base    = 12'd0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_rom_addr", int'(bus_if.rom_addr), 0);
        check("rst_vga_x", int'(bus_if.vga_x), 0);
        check("rst_vga_y", int'(bus_if.vga_y), 0);
        check("rst_colour", int'(bus_if.vga_colour), 0);
        check("rst_plot", int'(bus_if.vga_plot), 0);
        check("rst_done", int'(bus_if.draw_done), 0);
        check("rst_busy", int'(bus_if.busy), 0);
        tick();

        for (int i = 0; i < 7; i++) begin
            rom_mem[12'(vecs[i].base)]     = 3'(vecs[i].c0);
            rom_mem[12'(vecs[i].base + 1)] = 3'(vecs[i].c1);
            rom_mem[12'(vecs[i].base + 2)] = 3'(vecs[i].c2);
            rom_mem[12'(vecs[i].base + 3)] = 3'(vecs[i].c3);
            run_draw(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].base, 0);
            check($sformatf("v%0d_done_at", i), done_off, vecs[i].exp_done);
            check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
            check($sformatf("v%0d_nplots", i), plots.size(), vecs[i].exp_n);
            check($sformatf("v%0d_busy", i), busy_cnt, vecs[i].exp_busy);
            if (vecs[i].exp_n > 0 && plots.size() > 0) begin
                check($sformatf("v%0d_first_off", i), plots[0].off, vecs[i].f_off);
                check($sformatf("v%0d_first_x", i), plots[0].x, vecs[i].f_x);
                check($sformatf("v%0d_first_y", i), plots[0].y, vecs[i].f_y);
                check($sformatf("v%0d_first_c", i), plots[0].c, vecs[i].f_c);
                check($sformatf("v%0d_last_off", i), plots[$].off, vecs[i].l_off);
                check($sformatf("v%0d_last_x", i), plots[$].x, vecs[i].l_x);
                check($sformatf("v%0d_last_y", i), plots[$].y, vecs[i].l_y);
                check($sformatf("v%0d_last_c", i), plots[$].c, vecs[i].l_c);
            end
            if (i == 0) begin
                for (int k = 0; k < 4; k++)
                    check($sformatf("v0_rom_addr%0d", k), addr_log[2 + k], 'h040 + k);
                saved = plots;
            end
            tick();
        end

        // Request held long after done: exactly one draw, then a fresh identical one.
        run_draw(10, 20, 2, 2, 'h040, 20);
        check("hold_done_cnt", done_cnt, 1);
        check("hold_nplots", plots.size(), 4);
        run_draw(10, 20, 2, 2, 'h040, 0);
        check("redraw_nplots", plots.size(), saved.size());
        for (int k = 0; k < saved.size(); k++) begin
            if (k < plots.size()) begin
                check($sformatf("redraw_off%0d", k), plots[k].off, saved[k].off);
                check($sformatf("redraw_x%0d", k), plots[k].x, saved[k].x);
                check($sformatf("redraw_y%0d", k), plots[k].y, saved[k].y);
                check($sformatf("redraw_c%0d", k), plots[k].c, saved[k].c);
            end
        end

        // Abort: request dropped in RUN at N+3.
        bus_if.obj_x       = 8'd10;
        bus_if.obj_y       = 7'd20;
        bus_if.obj_w       = 6'd2;
        bus_if.obj_h       = 6'd2;
        bus_if.rom_base    = 12'h040;
        bus_if.enable_draw = 1'b1;
        repeat (3) tick();
        check("abort_busy_n3", int'(bus_if.busy), 1);
        check("abort_plot_n3", int'(bus_if.vga_plot), 1);
        bus_if.enable_draw = 1'b0;
        tick();
        check("abort_plot_n4", int'(bus_if.vga_plot), 0);
        check("abort_busy_n4", int'(bus_if.busy), 0);
        done_cnt = 0;
        n_plots  = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus_if.draw_done) done_cnt++;
            if (bus_if.vga_plot) n_plots++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_no_plots", n_plots, 0);

        // Synchronous reset at N+4 of a 4x4 draw.
        for (int a = 0; a < 16; a++) rom_mem[12'('h500 + a)] = 3'd1;
        bus_if.obj_x       = 8'd0;
        bus_if.obj_y       = 7'd0;
        bus_if.obj_w       = 6'd4;
        bus_if.obj_h       = 6'd4;
        bus_if.rom_base    = 12'h500;
        bus_if.enable_draw = 1'b1;
        repeat (4) tick();
        check("rstmid_plot_n4", int'(bus_if.vga_plot), 1);
        check("rstmid_x_n4", int'(bus_if.vga_x), 1);
        reset = 1'b1;
        tick();
        check("rstmid_plot_n5", int'(bus_if.vga_plot), 0);
        check("rstmid_done_n5", int'(bus_if.draw_done), 0);
        check("rstmid_busy_n5", int'(bus_if.busy), 0);
        check("rstmid_addr_n5", int'(bus_if.rom_addr), 0);
        reset              = 1'b0;
        bus_if.enable_draw = 1'b0;
        tick();
        check("rstmid_idle_busy", int'(bus_if.busy), 0);
        tick();
        run_draw(10, 20, 2, 2, 'h040, 0);
        check("post_rst_done_at", done_off, 7);
        check("post_rst_nplots", plots.size(), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
